// File: rtl/weight_class_counter_if.sv
// Beat stream in, per-frame class histogram out, for weight_class_counter.
// master = beat producer / histogram consumer, slave = the counter itself.
interface weight_class_counter_if #(
    parameter int N_CLASSES = 13,
    parameter int CNT_W     = 8,
    parameter int IDX_W     = 4
);
    logic                              in_valid;
    logic                              in_pixel;
    logic [IDX_W-1:0]                  in_class;
    logic                              in_last;
    logic                              in_ready;
    logic [N_CLASSES-1:0][CNT_W-1:0]   val;
    logic                              val_valid;
    logic [7:0]                        frame_id;
    logic                              sat;
    logic                              bad_class;

    modport master (
        output in_valid, in_pixel, in_class, in_last,
        input  in_ready, val, val_valid, frame_id, sat, bad_class
    );

    modport slave (
        input  in_valid, in_pixel, in_class, in_last,
        output in_ready, val, val_valid, frame_id, sat, bad_class
    );
endinterface

// File: rtl/weight_class_counter.sv
// Counts active pixels per weight class over a frame; publishes a double-buffered histogram.
// Latency: val/val_valid update on the edge sampling the in_last beat (visible 1 cycle later).
// Backpressure: none; in_ready is tied high and one beat per cycle is accepted forever.
module weight_class_counter #(
    parameter int N_CLASSES = 13,
    parameter int CNT_W     = 8,
    parameter int IDX_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    weight_class_counter_if.slave bus
);
    localparam logic [IDX_W:0]   N_CLS   = (IDX_W + 1)'(N_CLASSES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [N_CLASSES-1:0][CNT_W-1:0] acc;
    logic [N_CLASSES-1:0][CNT_W-1:0] acc_nxt;
    logic                            sat_acc;
    logic                            beat_sat;
    logic                            class_ok;
    logic                            count_beat;
    logic                            bad_beat;
    logic                            frame_end;

    assign class_ok   = {1'b0, bus.in_class} < N_CLS;
    assign count_beat = bus.in_valid & bus.in_pixel & class_ok;
    assign bad_beat   = bus.in_valid & bus.in_pixel & ~class_ok;
    assign frame_end  = bus.in_valid & bus.in_last;
    assign bus.in_ready = 1'b1;

    // Accumulation bank with the current beat applied; saturating, never wrapping.
    always_comb begin
        acc_nxt  = acc;
        beat_sat = 1'b0;
        for (int k = 0; k < N_CLASSES; k++) begin
            if (count_beat && bus.in_class == IDX_W'(k)) begin
                if (acc[k] == CNT_MAX) begin
                    beat_sat = 1'b1;
                end else begin
                    acc_nxt[k] = acc[k] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc           <= '0;
            sat_acc       <= 1'b0;
            bus.val       <= '0;
            bus.val_valid <= 1'b0;
            bus.frame_id  <= 8'd0;
            bus.sat       <= 1'b0;
            bus.bad_class <= 1'b0;
        end else begin
            bus.bad_class <= bus.bad_class | bad_beat;
            if (frame_end) begin
                // The closing beat lands in the output bank; the next beat sees a zeroed bank.
                bus.val       <= acc_nxt;
                bus.sat       <= sat_acc | beat_sat;
                bus.val_valid <= 1'b1;
                bus.frame_id  <= bus.frame_id + 8'd1;
                acc           <= '0;
                sat_acc       <= 1'b0;
            end else begin
                bus.val_valid <= 1'b0;
                acc           <= acc_nxt;
                sat_acc       <= sat_acc | beat_sat;
            end
        end
    end
endmodule

// File: tb/tb_weight_class_counter.sv
// Randomised and directed bench for weight_class_counter against an unbounded-count reference model.
module tb_weight_class_counter;
    localparam int NC = 13;

    logic clk;
    logic rst;

    weight_class_counter_if #(.N_CLASSES(13), .CNT_W(8), .IDX_W(4)) bus ();

    weight_class_counter #(.N_CLASSES(13), .CNT_W(8), .IDX_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: raw counts per class, clipped only when a frame is published.
    int m_cnt   [NC];
    int exp_val [NC];
    bit exp_sat;
    bit m_bad;
    int m_frames;
    int pulses;
    int vv_bad;

    function automatic logic [NC-1:0][7:0] exp_vec();
        logic [NC-1:0][7:0] v;
        for (int k = 0; k < NC; k++) v[k] = 8'(exp_val[k]);
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NC; k++) begin
            m_cnt[k]   = 0;
            exp_val[k] = 0;
        end
        exp_sat  = 0;
        m_bad    = 0;
        m_frames = 0;
        pulses   = 0;
        vv_bad   = 0;
    endtask

    // One clock of stimulus; inputs change and outputs are read on the falling edge.
    task automatic step(input bit v, input bit p, input int c, input bit l);
        bus.in_valid = v;
        bus.in_pixel = p;
        bus.in_class = 4'(c);
        bus.in_last  = l;
        @(posedge clk);
        if (v) begin
            if (p) begin
                if (c < NC) m_cnt[c]++;
                else        m_bad = 1;
            end
            if (l) begin
                exp_sat = 0;
                for (int k = 0; k < NC; k++) begin
                    exp_val[k] = (m_cnt[k] > 255) ? 255 : m_cnt[k];
                    if (m_cnt[k] > 255) exp_sat = 1;
                    m_cnt[k] = 0;
                end
                m_frames++;
            end
        end
        @(negedge clk);
        if (bus.val_valid !== (v && l)) vv_bad++;
        if (bus.val_valid === 1'b1) pulses++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 0; bus.in_pixel = 0; bus.in_class = 0; bus.in_last = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'($urandom);
            bus.in_pixel = 1'($urandom);
            bus.in_class = 4'($urandom);
            bus.in_last  = 1'($urandom);
            @(negedge clk);
        end
        n_checks++; if (bus.val !== '0) $display("FAIL reset val: got %h want 0", bus.val); else n_pass++;
        n_checks++; if (bus.val_valid !== 1'b0) $display("FAIL reset val_valid: got %b want 0", bus.val_valid); else n_pass++;
        n_checks++; if (bus.frame_id !== 8'd0) $display("FAIL reset frame_id: got %0d want 0", bus.frame_id); else n_pass++;
        n_checks++; if (bus.sat !== 1'b0) $display("FAIL reset sat: got %b want 0", bus.sat); else n_pass++;
        n_checks++; if (bus.bad_class !== 1'b0) $display("FAIL reset bad_class: got %b want 0", bus.bad_class); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", bus.in_ready); else n_pass++;
        bus.in_valid = 0; bus.in_pixel = 0; bus.in_class = 0; bus.in_last = 0;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_mnist_frame();
        do_reset();
        for (int i = 0; i < 784; i++) step(1, (i % 2) == 0, i % 13, i == 783);
        n_checks++; if (bus.val !== exp_vec()) $display("FAIL mnist val: got %h want %h", bus.val, exp_vec()); else n_pass++;
        n_checks++; if (bus.val[0] !== 8'd31) $display("FAIL mnist val0: got %0d want 31", bus.val[0]); else n_pass++;
        n_checks++; if (bus.val[1] !== 8'd30) $display("FAIL mnist val1: got %0d want 30", bus.val[1]); else n_pass++;
        n_checks++; if (bus.frame_id !== 8'd1) $display("FAIL mnist frame_id: got %0d want 1", bus.frame_id); else n_pass++;
        n_checks++; if (bus.sat !== 1'b0) $display("FAIL mnist sat: got %b want 0", bus.sat); else n_pass++;
        step(0, 0, 0, 0);
        n_checks++; if (pulses !== 1 || vv_bad !== 0) $display("FAIL mnist pulse: got %0d pulses %0d misplaced want 1/0", pulses, vv_bad); else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if (i > 0 && i % 50 == 0) begin
                step(0, 1, 5, 1);
                step(0, 1, 5, 1);
            end
            step(1, 1, 5, i == 299);
        end
        n_checks++; if (bus.val !== exp_vec()) $display("FAIL sat val: got %h want %h", bus.val, exp_vec()); else n_pass++;
        n_checks++; if (bus.val[5] !== 8'd255) $display("FAIL sat val5: got %0d want 255", bus.val[5]); else n_pass++;
        n_checks++; if (bus.sat !== 1'b1) $display("FAIL sat flag: got %b want 1", bus.sat); else n_pass++;
        n_checks++; if (pulses !== 1 || vv_bad !== 0) $display("FAIL sat pulse: got %0d pulses %0d misplaced want 1/0", pulses, vv_bad); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [NC-1:0][7:0] a_vec;
        int hold_bad;
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 1, 2, i == 9);
        n_checks++; if (bus.val[2] !== 8'd10) $display("FAIL b2b first val2: got %0d want 10", bus.val[2]); else n_pass++;
        a_vec = bus.val;
        hold_bad = 0;
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 12, i == 2);
            if (i < 2 && bus.val !== a_vec) hold_bad++;
        end
        n_checks++; if (hold_bad !== 0) $display("FAIL b2b hold: got %0d changes want 0", hold_bad); else n_pass++;
        n_checks++; if (bus.val[12] !== 8'd3 || bus.val[2] !== 8'd0) $display("FAIL b2b second: got v12=%0d v2=%0d want 3/0", bus.val[12], bus.val[2]); else n_pass++;
        n_checks++; if (bus.val !== exp_vec()) $display("FAIL b2b val: got %h want %h", bus.val, exp_vec()); else n_pass++;
        n_checks++; if (bus.frame_id !== 8'd2) $display("FAIL b2b frame_id: got %0d want 2", bus.frame_id); else n_pass++;
        step(0, 0, 0, 0);
        n_checks++; if (pulses !== 2 || vv_bad !== 0) $display("FAIL b2b pulse: got %0d pulses %0d misplaced want 2/0", pulses, vv_bad); else n_pass++;
    endtask

    task automatic test_bad_class();
        do_reset();
        step(1, 1, 13, 0);
        step(1, 1, 15, 0);
        step(1, 1, 0, 1);
        n_checks++; if (bus.bad_class !== 1'b1) $display("FAIL bad flag: got %b want 1", bus.bad_class); else n_pass++;
        n_checks++; if (bus.val[0] !== 8'd1 || bus.val !== exp_vec()) $display("FAIL bad val: got %h want %h", bus.val, exp_vec()); else n_pass++;
        step(1, 1, 7, 0);
        step(1, 1, 15, 1);
        step(1, 1, 4, 1);
        n_checks++; if (bus.bad_class !== 1'b1) $display("FAIL bad sticky: got %b want 1", bus.bad_class); else n_pass++;
        n_checks++; if (bus.val !== exp_vec()) $display("FAIL bad later val: got %h want %h", bus.val, exp_vec()); else n_pass++;
        n_checks++; if (bus.frame_id !== 8'd3) $display("FAIL bad frame_id: got %0d want 3", bus.frame_id); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int vv_seen;
        do_reset();
        for (int i = 0; i < 100; i++) step(1, 1, 3, 0);
        bus.in_last = 1'b1;
        #2 rst = 1'b1;
        vv_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.val_valid !== 1'b0) vv_seen++;
        end
        n_checks++; if (vv_seen !== 0) $display("FAIL rstmid val_valid: got %0d pulses want 0", vv_seen); else n_pass++;
        n_checks++; if (bus.val !== '0 || bus.frame_id !== 8'd0) $display("FAIL rstmid cleared: got %h fid %0d want 0", bus.val, bus.frame_id); else n_pass++;
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) step(1, 1, 3, i == 3);
        n_checks++; if (bus.val[3] !== 8'd4 || bus.val !== exp_vec()) $display("FAIL rstmid val: got %h want %h", bus.val, exp_vec()); else n_pass++;
        n_checks++; if (bus.frame_id !== 8'd1) $display("FAIL rstmid frame_id: got %0d want 1", bus.frame_id); else n_pass++;
        n_checks++; if (pulses !== 1 || vv_bad !== 0) $display("FAIL rstmid pulse: got %0d pulses %0d misplaced want 1/0", pulses, vv_bad); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int f = 0; f < 8; f++) begin
            int len;
            int hi;
            len = (f % 3 == 2) ? int'($urandom_range(280, 600)) : int'($urandom_range(1, 40));
            hi  = (f % 3 == 2) ? 1 : 15;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) step(0, 1'($urandom), int'($urandom_range(0, 15)), 1'($urandom));
                step(1, (hi == 1) ? 1'b1 : 1'($urandom), int'($urandom_range(0, hi)), i == len - 1);
            end
            n_checks++; if (bus.val !== exp_vec()) $display("FAIL rand val f%0d: got %h want %h", f, bus.val, exp_vec()); else n_pass++;
            n_checks++; if (bus.sat !== exp_sat) $display("FAIL rand sat f%0d: got %b want %b", f, bus.sat, exp_sat); else n_pass++;
            n_checks++; if (bus.frame_id !== 8'(m_frames)) $display("FAIL rand frame_id f%0d: got %0d want %0d", f, bus.frame_id, m_frames); else n_pass++;
            n_checks++; if (bus.bad_class !== m_bad) $display("FAIL rand bad f%0d: got %b want %b", f, bus.bad_class, m_bad); else n_pass++;
        end
        step(0, 0, 0, 0);
        n_checks++; if (pulses !== m_frames || vv_bad !== 0) $display("FAIL rand pulse: got %0d pulses %0d misplaced want %0d/0", pulses, vv_bad, m_frames); else n_pass++;
    endtask

    initial begin
        bus.in_valid = 0; bus.in_pixel = 0; bus.in_class = 0; bus.in_last = 0;
        rst = 1'b1;
        model_clear();
        test_reset();
        test_mnist_frame();
        test_saturation();
        test_back_to_back();
        test_bad_class();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/weight_class_counter.md
# weight_class_counter

Per-neuron histogram builder for the binarised MNIST datapath. It consumes a stream of (pixel, weight-class) beats and counts active pixels per power-of-two weight class (13 classes). At end of frame it presents the 13 counts as a registered, double-buffered vector with a one-cycle valid pulse. The vector feeds the weighted score adder; class k's count drives that adder's val[k] input.

## Interface
- N_CLASSES, 13, number of weight classes (class indices 0..N_CLASSES-1)
- CNT_W, 8, width of each class counter
- IDX_W, 4, width of the class index
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  beat present this cycle
- in_pixel  input  1  binarised pixel; beat counts only when 1
- in_class  input  IDX_W  weight class of this pixel's weight
- in_last  input  1  final beat of the frame
- in_ready  output  1  constant 1; the block never stalls
- val  output  CNT_W x N_CLASSES  registered counts of the last completed frame
- val_valid  output  1  one-cycle pulse: val updated this cycle
- frame_id  output  8  number of completed frames, modulo 256
- sat  output  1  some class counter saturated in the frame now on val
- bad_class  output  1  sticky; in_class >= N_CLASSES was seen with in_valid&in_pixel

One clock; reset is asynchronous and active-high.

## Operation
- Two banks:
  - accumulation bank acc[0..N_CLASSES-1], CNT_W each;
  - output bank, drives val.
- Counting beat: in_valid & in_pixel & (in_class < N_CLASSES). On a counting beat, acc[in_class] increments by 1.
- Saturation: acc saturates at 2^CNT_W-1 (255) and does not wrap. Any increment attempted at 255 sets the frame's sat_acc flag.
- Non-counting beats:
  - in_pixel=0 leaves acc unchanged.
  - in_class >= N_CLASSES leaves acc unchanged and sets bad_class. bad_class clears only on rst.
- End of frame: a beat with in_valid & in_last. That beat's own contribution is included. On the same clock edge:
  - output bank <= acc with that beat applied;
  - sat <= sat_acc | (that beat saturated);
  - all acc <= 0 and sat_acc <= 0;
  - frame_id increments (wrapping 255->0);
  - val_valid <= 1 for exactly one cycle.
- in_valid=0 cycles change nothing. Gaps inside a frame are allowed.
- in_last with in_valid=0 is ignored.
- Back-to-back frames:
  - A beat in the cycle right after in_last counts into the fresh, zeroed bank.
  - val holds its value until the next end-of-frame.
- A frame of one beat is legal: in_last on the first beat.
- val is not gated by val_valid. Downstream may sample val at any time after the pulse.

## Timing
- Reset values: all acc = 0, val = all 0, val_valid = 0, frame_id = 0, sat = 0, bad_class = 0, in_ready = 1.
- Latency: val and val_valid update on the rising edge that samples the in_last beat. Both are visible the next cycle, so the last beat to val_valid is 1 cycle.
- The downstream score adder adds 2 more cycles.
- Throughput: one beat per cycle, sustained indefinitely, including across frame boundaries.
- rst mid-frame: partial counts are discarded, the output bank is cleared, and any pending val_valid is dropped. The first post-reset beat starts a new frame.
- An in_last beat with a bad class still ends the frame and also sets bad_class.

## Test plan
- Reset → val all 0, val_valid=0, frame_id=0, sat=0, bad_class=0, in_ready=1.
- Frame of 784 beats: class = i mod 13, in_pixel=1 on even i only, in_last on i=783 → val[k] = number of even i with i mod 13 = k (e.g. val[0]=31, val[1]=30). val_valid pulses once, 1 cycle after the last beat. frame_id=1.
- Frame of 300 beats, all class 5, in_pixel=1, with 2-cycle gaps every 50 beats → val[5]=255, all others 0, sat=1.
- Back-to-back frames, no gap:
  - frame A: 10 beats of class 2;
  - frame B: 3 beats of class 12, starting the cycle after A's in_last.
  - Expected: first pulse val[2]=10; second pulse val[12]=3 and val[2]=0. Exactly two pulses. frame_id=2. val holds A's counts between the pulses.
- Beats with in_class=13 and in_class=15, plus a single-beat frame (class 0, in_last) → bad_class=1 and stays 1 across frames; val[0]=1, all others 0.
- Assert rst after 100 beats of class 3, then run a 4-beat class-3 frame → val[3]=4, frame_id=1, no val_valid during or just after reset.
